// File: rtl/gcd_pkg.sv
// Shared types for the GCD request front-end.
package gcd_pkg;

  // Request sequencer FSM states.
  typedef enum logic [1:0] {
    RQ_IDLE  = 2'd0,
    RQ_ISSUE = 2'd1,
    RQ_WAIT  = 2'd2,
    RQ_RESP  = 2'd3
  } req_state_t;

endpackage

// File: rtl/gcd_req_fifo.sv
// Synchronous request FIFO. Read data comes straight out of the storage
// flops at the read pointer, so a word written this cycle is only visible
// from the next cycle on (no write-to-read bypass).
module gcd_req_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign do_push   = push_i && !full_o;
  assign do_pop    = pop_i && !empty_o;
  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign rd_data_o = mem_q[rd_ptr_q];

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/gcd_req_sequencer.sv
// Front-end for the GCD core: queues tagged operand pairs, issues them to
// the core one at a time, bounds each core operation with a watchdog and
// returns {gcd, tag, err} in request order. Zero operands never reach the core.
module gcd_req_sequencer
  import gcd_pkg::*;
#(
  parameter int XLEN    = 16,
  parameter int DEPTH   = 4,
  parameter int TAGW    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [XLEN-1:0] req_a_i,
  input  logic [XLEN-1:0] req_b_i,
  input  logic [TAGW-1:0] req_tag_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] rsp_gcd_o,
  output logic [TAGW-1:0] rsp_tag_o,
  output logic            rsp_err_o,
  output logic            core_ld_o,
  output logic [XLEN-1:0] core_a_o,
  output logic [XLEN-1:0] core_b_o,
  input  logic            core_done_i,
  input  logic [XLEN-1:0] core_gcd_i,
  output logic            busy_o
);
  localparam int FW  = 2*XLEN + TAGW;
  localparam int WDW = $clog2(TIMEOUT);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  req_state_t      state_q, state_d;
  logic            fifo_full, fifo_empty, pop;
  logic [FW-1:0]   fifo_rd_data;
  logic [XLEN-1:0] head_a, head_b;
  logic [TAGW-1:0] head_tag;
  logic            head_zero;
  logic [XLEN-1:0] a_q, b_q, gcd_q;
  logic [TAGW-1:0] tag_q;
  logic            err_q;
  logic [WDW-1:0]  wd_q, wd_inc;
  logic            done_ok, wd_expired;

  assign {head_a, head_b, head_tag} = fifo_rd_data;
  assign head_zero  = (head_a == '0) || (head_b == '0);
  assign pop        = (state_q == RQ_IDLE) && !fifo_empty;
  assign wd_inc     = wd_q + WDW'(1);
  // wd_q is zero only in the first WAIT cycle, where a done left over from
  // the previous operation may still be showing.
  assign done_ok    = core_done_i && (wd_q != '0);
  assign wd_expired = (wd_inc == WD_LAST);

  gcd_req_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push_i    (req_valid_i),
    .wr_data_i ({req_a_i, req_b_i, req_tag_i}),
    .pop_i     (pop),
    .rd_data_o (fifo_rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Next-state selection; done takes priority over the watchdog.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RQ_IDLE:  if (pop) state_d = head_zero ? RQ_RESP : RQ_ISSUE;
      RQ_ISSUE: state_d = RQ_WAIT;
      RQ_WAIT:  if (done_ok || wd_expired) state_d = RQ_RESP;
      RQ_RESP:  if (rsp_ready_i) state_d = RQ_IDLE;
      default:  state_d = RQ_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= RQ_IDLE;
    else         state_q <= state_d;
  end

  // Operand/tag capture, watchdog and response registers. core_gcd_i is
  // only looked at when a qualified done is present, so a floating bus
  // never reaches the response.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      a_q   <= '0;
      b_q   <= '0;
      tag_q <= '0;
      gcd_q <= '0;
      err_q <= 1'b0;
      wd_q  <= '0;
    end else begin
      if (pop) begin
        a_q   <= head_a;
        b_q   <= head_b;
        tag_q <= head_tag;
        if (head_zero) begin
          gcd_q <= head_a | head_b;
          err_q <= 1'b0;
        end
      end
      if (state_q == RQ_ISSUE) wd_q <= '0;
      if (state_q == RQ_WAIT) begin
        wd_q <= wd_inc;
        if (done_ok) begin
          gcd_q <= core_gcd_i;
          err_q <= 1'b0;
        end else if (wd_expired) begin
          gcd_q <= '0;
          err_q <= 1'b1;
        end
      end
    end
  end

  assign req_ready_o = !fifo_full;
  assign rsp_valid_o = (state_q == RQ_RESP);
  assign rsp_gcd_o   = gcd_q;
  assign rsp_tag_o   = tag_q;
  assign rsp_err_o   = err_q;
  assign core_ld_o   = (state_q == RQ_ISSUE);
  assign core_a_o    = a_q;
  assign core_b_o    = b_q;
  assign busy_o      = (state_q != RQ_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_gcd_req_sequencer.sv
// Bench for gcd_req_sequencer: models the GCD core and checks responses
// against an arithmetic GCD reference and an in-order expectation queue.
module tb_gcd_req_sequencer;
  localparam int XLEN    = 16;
  localparam int DEPTH   = 4;
  localparam int TAGW    = 4;
  localparam int TIMEOUT = 64;
  localparam int BOUND   = 500;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            req_valid_i = 1'b0;
  logic            req_ready_o;
  logic [XLEN-1:0] req_a_i = '0;
  logic [XLEN-1:0] req_b_i = '0;
  logic [TAGW-1:0] req_tag_i = '0;
  logic            rsp_valid_o;
  logic            rsp_ready_i = 1'b0;
  logic [XLEN-1:0] rsp_gcd_o;
  logic [TAGW-1:0] rsp_tag_o;
  logic            rsp_err_o;
  logic            core_ld_o;
  logic [XLEN-1:0] core_a_o, core_b_o;
  logic            core_done_i = 1'b0;
  logic [XLEN-1:0] core_gcd_i = 'z;
  logic            busy_o;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // core model: 0 fixed latency, 1 stale done held over from last op,
  // 2 never done, 3 random latency
  int core_mode = 0;
  int core_lat  = 2;
  int core_cnt  = 0;
  int ld_cnt    = 0;
  int ld_cyc    = 0;
  logic [XLEN-1:0] core_res;

  logic [XLEN+TAGW:0] exp_q[$];

  gcd_req_sequencer #(
    .XLEN(XLEN), .DEPTH(DEPTH), .TAGW(TAGW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .resetn(resetn),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_a_i(req_a_i), .req_b_i(req_b_i), .req_tag_i(req_tag_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_gcd_o(rsp_gcd_o), .rsp_tag_o(rsp_tag_o), .rsp_err_o(rsp_err_o),
    .core_ld_o(core_ld_o), .core_a_o(core_a_o), .core_b_o(core_b_o),
    .core_done_i(core_done_i), .core_gcd_i(core_gcd_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [XLEN-1:0] gcd_ref(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic [XLEN-1:0] x, y, t;
    x = a; y = b;
    while (y != 0) begin
      t = x % y; x = y; y = t;
    end
    return x;
  endfunction

  always @(negedge clk) begin
    if (!resetn) begin
      core_done_i = 1'b0; core_gcd_i = 'z; core_cnt = 0;
    end else if (core_ld_o) begin
      ld_cnt = ld_cnt + 1;
      ld_cyc = cyc;
      core_res = gcd_ref(core_a_o, core_b_o);
      core_cnt = (core_mode == 3) ? int'($urandom_range(1, 8)) : core_lat;
      if (core_mode != 1) begin
        core_done_i = 1'b0; core_gcd_i = 'z;
      end
    end else if (core_cnt > 0 && core_mode != 2) begin
      core_cnt = core_cnt - 1;
      if (core_cnt == 0) begin
        core_done_i = 1'b1; core_gcd_i = core_res;
      end
    end
  end

  task automatic push_req(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [TAGW-1:0] t, output bit ok, output int acc_cyc);
    int n;
    req_a_i = a; req_b_i = b; req_tag_i = t; req_valid_i = 1'b1;
    n = 0;
    while (!req_ready_o && n < BOUND) begin
      @(negedge clk); n++;
    end
    ok = req_ready_o;
    acc_cyc = cyc;
    @(negedge clk);
    req_valid_i = 1'b0;
  endtask

  task automatic get_rsp(output logic [XLEN-1:0] g, output logic [TAGW-1:0] t,
                         output logic e, output bit ok, output int rc);
    int n;
    n = 0;
    while (!rsp_valid_o && n < BOUND) begin
      @(negedge clk); n++;
    end
    ok = rsp_valid_o; g = rsp_gcd_o; t = rsp_tag_o; e = rsp_err_o; rc = cyc;
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [3*XLEN+TAGW+3:0] outs;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    outs = {rsp_valid_o, rsp_gcd_o, rsp_tag_o, rsp_err_o, core_ld_o, core_a_o, core_b_o, busy_o};
    checks++;
    if (outs !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    checks++;
    if (req_ready_o !== 1'b1) begin
      errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready_o);
    end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [XLEN-1:0] g; logic [TAGW-1:0] t; logic e; bit ok; int pc, rc, l0;
    core_mode = 0; core_lat = 3; l0 = ld_cnt;
    push_req(16'd48, 16'd18, 4'd3, ok, pc);
    get_rsp(g, t, e, ok, rc);
    checks++;
    if (!ok || {g, t, e} !== {16'd6, 4'd3, 1'b0}) begin
      errors++; $display("FAIL single_rsp: got valid=%b gcd=%0d tag=%0d err=%b expected gcd=6 tag=3 err=0", ok, g, t, e);
    end
    checks++;
    if (rc - pc < 4) begin
      errors++; $display("FAIL single_latency: got %0d expected >=4", rc - pc);
    end
    checks++;
    if (ld_cnt - l0 != 1) begin
      errors++; $display("FAIL single_ld_pulses: got %0d expected 1", ld_cnt - l0);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (busy_o !== 1'b0) begin
      errors++; $display("FAIL single_idle_busy: got %b expected 0", busy_o);
    end
  endtask

  task automatic test_zero();
    logic [XLEN-1:0] g; logic [TAGW-1:0] t; logic e; bit ok; int pc1, pc2, rc, l0;
    l0 = ld_cnt;
    push_req(16'd0, 16'd35, 4'd1, ok, pc1);
    push_req(16'd0, 16'd0, 4'd2, ok, pc2);
    get_rsp(g, t, e, ok, rc);
    checks++;
    if (!ok || {g, t, e} !== {16'd35, 4'd1, 1'b0}) begin
      errors++; $display("FAIL zero_rsp1: got valid=%b gcd=%0d tag=%0d err=%b expected gcd=35 tag=1 err=0", ok, g, t, e);
    end
    checks++;
    if (rc - pc1 != 2) begin
      errors++; $display("FAIL zero_latency: got %0d expected 2", rc - pc1);
    end
    get_rsp(g, t, e, ok, rc);
    checks++;
    if (!ok || {g, t, e} !== {16'd0, 4'd2, 1'b0}) begin
      errors++; $display("FAIL zero_rsp2: got valid=%b gcd=%0d tag=%0d err=%b expected gcd=0 tag=2 err=0", ok, g, t, e);
    end
    checks++;
    if (ld_cnt != l0) begin
      errors++; $display("FAIL zero_no_ld: got %0d pulses expected 0", ld_cnt - l0);
    end
  endtask

  task automatic test_backpressure();
    logic [XLEN-1:0] ra[DEPTH+2], rb[DEPTH+2];
    logic [TAGW-1:0] rt[DEPTH+2];
    logic [XLEN+TAGW:0] hold;
    int acc, stall_bad, hold_bad;
    core_mode = 0; core_lat = 2;
    for (int i = 0; i < DEPTH + 2; i++) begin
      int gg;
      gg = $urandom_range(1, 20);
      ra[i] = XLEN'(gg * $urandom_range(1, 30));
      rb[i] = XLEN'(gg * $urandom_range(0, 30));
      rt[i] = TAGW'(i + 5);
    end
    acc = 0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      bit ok; int pc;
      push_req(ra[i], rb[i], rt[i], ok, pc);
      if (ok) acc++;
    end
    checks++;
    if (acc != DEPTH + 1) begin
      errors++; $display("FAIL bp_accepted: got %0d expected %0d", acc, DEPTH + 1);
    end
    req_a_i = ra[DEPTH+1]; req_b_i = rb[DEPTH+1]; req_tag_i = rt[DEPTH+1]; req_valid_i = 1'b1;
    repeat (3) @(negedge clk);
    stall_bad = 0; hold_bad = 0;
    hold = {rsp_gcd_o, rsp_tag_o, rsp_err_o};
    for (int k = 0; k < 5; k++) begin
      if (req_ready_o !== 1'b0) stall_bad++;
      if (rsp_valid_o !== 1'b1 || {rsp_gcd_o, rsp_tag_o, rsp_err_o} !== hold) hold_bad++;
      @(negedge clk);
    end
    checks++;
    if (stall_bad != 0) begin
      errors++; $display("FAIL bp_stall: got ready=1 in %0d cycles expected 0", stall_bad);
    end
    checks++;
    if (hold_bad != 0 || hold !== {gcd_ref(ra[0], rb[0]), rt[0], 1'b0}) begin
      errors++; $display("FAIL bp_rsp_hold: got %h (%0d unstable cycles) expected %h", hold, hold_bad, {gcd_ref(ra[0], rb[0]), rt[0], 1'b0});
    end
    fork
      begin
        bit ok; int pc;
        push_req(ra[DEPTH+1], rb[DEPTH+1], rt[DEPTH+1], ok, pc);
        checks++;
        if (!ok) begin
          errors++; $display("FAIL bp_release_push: got ready=0 expected 1");
        end
      end
      begin
        for (int i = 0; i < DEPTH + 2; i++) begin
          logic [XLEN-1:0] g; logic [TAGW-1:0] t; logic e; bit ok; int rc;
          get_rsp(g, t, e, ok, rc);
          checks++;
          if (!ok || {g, t, e} !== {gcd_ref(ra[i], rb[i]), rt[i], 1'b0}) begin
            errors++; $display("FAIL bp_order[%0d]: got valid=%b %0d/%0d/%b expected %0d/%0d/0", i, ok, g, t, e, gcd_ref(ra[i], rb[i]), rt[i]);
          end
        end
      end
    join
  endtask

  task automatic test_timeout();
    logic [XLEN-1:0] g; logic [TAGW-1:0] t; logic e; bit ok; int pc, rc;
    core_mode = 2;
    push_req(16'd100, 16'd75, 4'd9, ok, pc);
    get_rsp(g, t, e, ok, rc);
    checks++;
    if (!ok || {g, t, e} !== {16'd0, 4'd9, 1'b1}) begin
      errors++; $display("FAIL timeout_rsp: got valid=%b gcd=%0d tag=%0d err=%b expected gcd=0 tag=9 err=1", ok, g, t, e);
    end
    checks++;
    if (rc - ld_cyc != TIMEOUT) begin
      errors++; $display("FAIL timeout_cycles: got %0d expected %0d", rc - ld_cyc, TIMEOUT);
    end
    core_mode = 0; core_lat = 2;
    push_req(16'd21, 16'd14, 4'd10, ok, pc);
    get_rsp(g, t, e, ok, rc);
    checks++;
    if (!ok || {g, t, e} !== {16'd7, 4'd10, 1'b0}) begin
      errors++; $display("FAIL timeout_next: got valid=%b gcd=%0d tag=%0d err=%b expected gcd=7 tag=10 err=0", ok, g, t, e);
    end
  endtask

  task automatic test_stale_done();
    logic [XLEN-1:0] g; logic [TAGW-1:0] t; logic e; bit ok; int pc, rc;
    core_mode = 0; core_lat = 1;
    push_req(16'd30, 16'd12, 4'd4, ok, pc);
    get_rsp(g, t, e, ok, rc);
    checks++;
    if (!ok || {g, t, e} !== {16'd6, 4'd4, 1'b0}) begin
      errors++; $display("FAIL stale_first: got valid=%b gcd=%0d tag=%0d err=%b expected gcd=6 tag=4 err=0", ok, g, t, e);
    end
    core_mode = 1; core_lat = 2;
    push_req(16'd35, 16'd49, 4'd5, ok, pc);
    get_rsp(g, t, e, ok, rc);
    checks++;
    if (!ok || {g, t, e} !== {16'd7, 4'd5, 1'b0}) begin
      errors++; $display("FAIL stale_rsp: got valid=%b gcd=%0d tag=%0d err=%b expected gcd=7 tag=5 err=0", ok, g, t, e);
    end
    checks++;
    if (rc - ld_cyc != 3) begin
      errors++; $display("FAIL stale_latency: got %0d expected 3", rc - ld_cyc);
    end
    core_mode = 0;
  endtask

  task automatic test_reset_mid();
    logic [3*XLEN+TAGW+3:0] outs;
    logic [XLEN-1:0] g; logic [TAGW-1:0] t; logic e; bit ok; int pc, rc, l0, quiet_bad;
    core_mode = 2;
    push_req(16'd9, 16'd6, 4'd1, ok, pc);
    push_req(16'd8, 16'd4, 4'd2, ok, pc);
    push_req(16'd0, 16'd5, 4'd3, ok, pc);
    repeat (2) @(negedge clk);
    checks++;
    if (busy_o !== 1'b1 || rsp_valid_o !== 1'b0) begin
      errors++; $display("FAIL midreset_pre: got busy=%b valid=%b expected busy=1 valid=0", busy_o, rsp_valid_o);
    end
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    outs = {rsp_valid_o, rsp_gcd_o, rsp_tag_o, rsp_err_o, core_ld_o, core_a_o, core_b_o, busy_o};
    checks++;
    if (outs !== '0 || req_ready_o !== 1'b1) begin
      errors++; $display("FAIL midreset_outputs: got %h ready=%b expected 0 ready=1", outs, req_ready_o);
    end
    resetn = 1'b1;
    core_mode = 0; core_lat = 2;
    l0 = ld_cnt; quiet_bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0) quiet_bad++;
    end
    checks++;
    if (quiet_bad != 0 || ld_cnt != l0) begin
      errors++; $display("FAIL midreset_quiet: got %0d active cycles %0d ld pulses expected 0", quiet_bad, ld_cnt - l0);
    end
    push_req(16'd27, 16'd18, 4'd12, ok, pc);
    get_rsp(g, t, e, ok, rc);
    checks++;
    if (!ok || {g, t, e} !== {16'd9, 4'd12, 1'b0}) begin
      errors++; $display("FAIL midreset_after: got valid=%b gcd=%0d tag=%0d err=%b expected gcd=9 tag=12 err=0", ok, g, t, e);
    end
  endtask

  task automatic test_random();
    localparam int NR = 24;
    core_mode = 3;
    exp_q.delete();
    fork
      begin
        for (int i = 0; i < NR; i++) begin
          logic [XLEN-1:0] a, b; logic [TAGW-1:0] tg; int gg, x, y; bit ok; int pc;
          repeat ($urandom_range(0, 3)) @(negedge clk);
          gg = $urandom_range(1, 40);
          x = $urandom_range(0, 50); y = $urandom_range(0, 50);
          if ($urandom_range(0, 5) == 0) x = 0;
          if ($urandom_range(0, 5) == 0) y = 0;
          a = XLEN'(gg * x); b = XLEN'(gg * y); tg = TAGW'(i);
          exp_q.push_back({gcd_ref(a, b), tg, 1'b0});
          push_req(a, b, tg, ok, pc);
          checks++;
          if (!ok) begin
            errors++; $display("FAIL rand_push[%0d]: got ready=0 expected 1", i);
          end
        end
      end
      begin
        for (int i = 0; i < NR; i++) begin
          int n; bit got, rdy; logic [XLEN+TAGW:0] obs, exp;
          n = 0; got = 0; obs = '0;
          while (!got && n < BOUND) begin
            @(negedge clk);
            rdy = ($urandom_range(0, 3) != 0);
            rsp_ready_i = rdy;
            if (rsp_valid_o && rdy) begin
              got = 1; obs = {rsp_gcd_o, rsp_tag_o, rsp_err_o};
            end
            n++;
          end
          checks++;
          if (!got) begin
            errors++; $display("FAIL rand_rsp[%0d]: got no response expected one within %0d cycles", i, BOUND);
          end else if (exp_q.size() == 0) begin
            errors++; $display("FAIL rand_rsp[%0d]: got %h expected no response", i, obs);
          end else begin
            exp = exp_q.pop_front();
            if (obs !== exp) begin
              errors++; $display("FAIL rand_rsp[%0d]: got %h expected %h", i, obs, exp);
            end
          end
        end
        @(negedge clk);
        rsp_ready_i = 1'b0;
      end
    join
    core_mode = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || exp_q.size() != 0) begin
      errors++; $display("FAIL rand_drain: got busy=%b left=%0d expected busy=0 left=0", busy_o, exp_q.size());
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_zero();
    test_backpressure();
    test_timeout();
    test_stale_done();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
